// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory once per cycle and
// buffers {pc, insn} pairs in a small FIFO so decode can stall without losing fetches.
module fetch_queue_unit #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [ILEN-1:0] imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_insn
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_q   [DEPTH];
  logic [ILEN-1:0] insn_q [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW:0]     count;
  logic            push;
  logic            pop;

  // Fetch targets are word aligned; the low two bits of a redirect are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // A full queue can still accept a fetch when the head leaves in the same cycle.
  assign push       = !reset && !redirect_valid && ((count < FULL_CNT) || pop);
  assign imem_rd_en = push;
  assign imem_addr  = pc;
  assign out_pc     = pc_q[rd_ptr];
  assign out_insn   = insn_q[rd_ptr];

  // Control state: PC, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc     <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      pc     <= align_word(redirect_pc);
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + PC_STEP;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage carries data only and is never reset.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_q[wr_ptr]   <= pc;
      insn_q[wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a driver predicts the fetched stream,
// a negedge monitor compares the DUT head and memory-side outputs against it.
module tb_fetch_queue_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_insn;

  int total = 0;
  int bad   = 0;

  ent_t        exp_q[$];
  logic [31:0] model_pc  = '0;
  logic        known     = 1'b0;
  logic        chk_en    = 1'b0;
  logic [31:0] exp_addr  = '0;
  logic        exp_rd_en = 1'b0;
  logic        p_push    = 1'b0;
  logic        p_flush   = 1'b0;
  ent_t        p_ent;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = mem_fn(imem_addr);

  always #5 clock = ~clock;

  fetch_queue_unit #(
    .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_addr(imem_addr),
    .imem_rd_en(imem_rd_en),
    .imem_data(imem_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_insn(out_insn)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: commit last cycle's effect on the expected stream,
  // drive new inputs, and predict this cycle's memory-side outputs.
  task automatic drive_cycle(input logic rst, input logic rv, input logic [31:0] rpc,
                             input logic rdy);
    logic psh;
    @(posedge clock);
    #1;
    if (p_flush) exp_q.delete();
    else if (p_push) exp_q.push_back(p_ent);
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    chk_en         = known;
    exp_addr       = model_pc;
    psh = !rst && !rv && ((exp_q.size() < DEPTH) || (rdy && exp_q.size() > 0));
    exp_rd_en    = psh;
    p_push       = psh;
    p_flush      = rst || rv;
    p_ent.pc     = model_pc;
    p_ent.insn   = mem_fn(model_pc);
    if (rst) begin
      model_pc = RESET_PC;
      known    = 1'b1;
    end else if (rv) begin
      model_pc = rpc & 32'hFFFF_FFFC;
    end else if (psh) begin
      model_pc = model_pc + 32'd4;
    end
  endtask

  // Monitor: compares at negedge, pops the expected head on an accepted transfer.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("imem_addr", imem_addr, exp_addr);
        chk("imem_rd_en", 32'(imem_rd_en), 32'(exp_rd_en));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          if (out_valid) begin
            chk("out_pc", out_pc, exp_q[0].pc);
            chk("out_insn", out_insn, exp_q[0].insn);
          end
          if (out_ready && !reset && !redirect_valid) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset then streaming with decode always ready.
    repeat (2) drive_cycle(1, 0, '0, 0);
    repeat (6) drive_cycle(0, 0, '0, 1);

    // Stall until full, then drain and resume.
    repeat (2) drive_cycle(1, 0, '0, 0);
    repeat (8) drive_cycle(0, 0, '0, 0);
    chk("stall_addr", imem_addr, 32'h0100_0010);
    chk("stall_rd_en", 32'(imem_rd_en), 32'd0);
    chk("stall_head", out_pc, 32'h0100_0000);
    repeat (8) drive_cycle(0, 0, '0, 1);

    // Full queue with ready toggling.
    repeat (4) drive_cycle(0, 0, '0, 0);
    for (int i = 0; i < 12; i++) drive_cycle(0, 0, '0, 1'(i % 2));

    // Redirect with three entries queued.
    drive_cycle(1, 0, '0, 0);
    repeat (3) drive_cycle(0, 0, '0, 0);
    drive_cycle(0, 1, 32'h0100_0203, 1);
    drive_cycle(0, 0, '0, 1);
    chk("redir_addr", imem_addr, 32'h0100_0200);
    chk("redir_valid", 32'(out_valid), 32'd0);
    drive_cycle(0, 0, '0, 1);
    chk("redir_head", out_pc, 32'h0100_0200);
    repeat (3) drive_cycle(0, 0, '0, 1);

    // Reset and redirect together mid-stream.
    for (int i = 0; i < 5; i++) drive_cycle(0, 0, '0, 1'($urandom_range(1)));
    drive_cycle(1, 1, 32'h0000_4444, 1);
    drive_cycle(0, 0, '0, 1);
    chk("rstredir_addr", imem_addr, 32'h0100_0000);
    chk("rstredir_valid", 32'(out_valid), 32'd0);
    repeat (3) drive_cycle(0, 0, '0, 1);

    // PC wrap at the top of the address space.
    drive_cycle(0, 1, 32'hFFFF_FFFC, 1);
    drive_cycle(0, 0, '0, 1);
    drive_cycle(0, 0, '0, 1);
    chk("wrap_head0", out_pc, 32'hFFFF_FFFC);
    drive_cycle(0, 0, '0, 1);
    chk("wrap_head1", out_pc, 32'h0000_0000);
    repeat (3) drive_cycle(0, 0, '0, 1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      drive_cycle(1'($urandom_range(63) == 0), 1'($urandom_range(15) == 0),
                  $urandom, 1'($urandom_range(1)));
    end
    repeat (2) drive_cycle(0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Parameterised instruction-fetch stage: owns the program counter, issues one instruction-memory read per cycle, and buffers fetched {pc, instruction} pairs in a small FIFO so that decode can stall via a valid/ready handshake without losing fetches. It supports a one-cycle redirect (branch/jump target) that flushes the queue and restarts fetch. It sits between the instruction memory and decode in the processor pipeline.

## Interface
- `RESET_PC`, default 32'h0100_0000: PC value loaded on reset.
- `XLEN`, default 32: PC and address width.
- `ILEN`, default 32: instruction word width.
- `DEPTH`, default 4: queue entries; power of two, ≥2.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `redirect_valid`  in  1  load new fetch PC this cycle.
- `redirect_pc`  in  XLEN  redirect target; bits [1:0] are forced to 0.
- `imem_addr`  out  XLEN  read address; equals current PC.
- `imem_rd_en`  out  1  high when the read data in this cycle is captured.
- `imem_data`  in  ILEN  instruction at `imem_addr`, combinational (valid the same cycle).
- `out_valid`  out  1  queue head holds a valid entry.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_pc`  out  XLEN  PC of head entry.
- `out_insn`  out  ILEN  instruction of head entry.

## Operation
- State: `pc` (XLEN), queue storage DEPTH×(XLEN+ILEN), read/write pointers (log2 DEPTH bits, wrap modulo DEPTH), occupancy count (log2 DEPTH + 1 bits, range 0..DEPTH).
- `imem_addr` = `pc` always, including during reset.
- pop = `out_valid & out_ready`.
- push = `!reset & !redirect_valid & (count < DEPTH | pop)`; `imem_rd_en` = push.
- On push: write {pc, imem_data} at write pointer; `pc <= pc + 4` (modulo 2^XLEN, wraps from all-ones region to 0 with no flag).
- On pop: advance read pointer.
- count updates: push only +1, pop only −1, both or neither unchanged.
- Full (count == DEPTH) with no pop: no push, `pc` holds, memory read ignored.
- Full with pop: push and pop in the same cycle; count stays DEPTH.
- Empty: `out_valid` = 0; `out_pc`/`out_insn` are don't-care; `out_ready` has no effect.
- Redirect (`redirect_valid` = 1, `reset` = 0): `pc <= {redirect_pc[XLEN-1:2], 2'b00}`; pointers and count cleared; no push this cycle. A pop asserted in the same cycle is treated as accepted by the consumer but has no further effect (queue flushed anyway).
- Reset: `pc <= RESET_PC`, pointers and count <= 0; overrides redirect, push and pop. Reset mid-stream discards all queued entries.
- No FSM beyond the count; the unit is always fetching unless full, redirecting or in reset.

## Timing
- Reset values (cycle after reset sampled high): `imem_addr` = RESET_PC, `out_valid` = 0, `imem_rd_en` = 0 while reset is high, 1 once reset is low.
- Fetch-to-output latency: 1 cycle. An instruction captured in cycle N appears at head, `out_valid` = 1, in cycle N+1 if the queue was empty.
- First cycle after reset deasserts (cycle 0): fetch at RESET_PC; cycle 1: `out_valid` = 1, `out_pc` = RESET_PC.
- Redirect in cycle R: cycle R+1 `imem_addr` = target, `out_valid` = 0; cycle R+2 `out_pc` = target.
- Steady state with `out_ready` held high: one instruction per cycle, PCs consecutive in steps of 4.
- Outputs `out_*` are driven from the registered queue head (no combinational path from `imem_data` or `out_ready` to `out_*`). `imem_rd_en` depends combinationally on `out_ready`, `redirect_valid` and `reset`.

## Test plan
- Reset, then `out_ready` = 1 for 6 cycles: `out_pc` = 0x0100_0000, 0x0100_0004, … 0x0100_0014 on consecutive cycles starting cycle 1; `out_insn` matches memory model.
- `out_ready` = 0 for 8 cycles after reset: count reaches 4, `imem_addr` holds 0x0100_0010, `imem_rd_en` = 0; release `out_ready`: entries 0x0100_0000..0x0100_000C drain in order, then fetch resumes at 0x0100_0010 with no gap or duplicate.
- Full queue with `out_ready` = 1 toggled every other cycle: no entry lost or duplicated; count never exceeds 4.
- Redirect to 0x0100_0203 while queue holds 3 entries: next cycle `out_valid` = 0, `imem_addr` = 0x0100_0200; two cycles later `out_pc` = 0x0100_0200.
- Reset and redirect asserted together mid-stream: `imem_addr` = 0x0100_0000 next cycle, queue empty, redirect ignored.
- PC wrap: redirect to 0xFFFF_FFFC: fetched entries show PC 0xFFFF_FFFC then 0x0000_0000.
